// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci/Lucas sequence engine.
// Seeds are plain integers and are sized to the datapath width where they are used.
package fibo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StFinish
  } state_e;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;

  localparam int unsigned FIB_T0 = 0;
  localparam int unsigned FIB_T1 = 1;
  localparam int unsigned LUC_T0 = 2;
  localparam int unsigned LUC_T1 = 1;

  function automatic int unsigned seed_t0(input logic mode);
    return (mode == MODE_LUCAS) ? LUC_T0 : FIB_T0;
  endfunction

  function automatic int unsigned seed_t1(input logic mode);
    return (mode == MODE_FIB) ? FIB_T1 : LUC_T1;
  endfunction

endpackage

// File: rtl/fibo_add_stage.sv
// Combinational WIDTH-bit unsigned adder that also returns the carry out.
// The carry out marks a wrapped sum.
module fibo_add_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/fibo_seq_engine.sv
// Streams terms T0..Tn of a Fibonacci or Lucas sequence over valid/ready.
// The final term is registered on data, together with a sticky wrap flag and a done pulse.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic             term_valid,
  output logic [WIDTH-1:0] term_data,
  input  logic             term_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  // Taint bits: set when a register holds a term derived from a wrapped sum.
  logic             a_c_q;
  logic             b_c_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx_q;
  logic             mode_q;
  logic             handshake;

  fibo_add_stage #(
    .WIDTH(WIDTH)
  ) u_add (
    .a        (a_q),
    .b        (b_q),
    .sum      (sum),
    .carry_out(carry_out)
  );

  assign handshake = term_valid & term_ready;
  assign term_data = a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      a_c_q      <= 1'b0;
      b_c_q      <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      mode_q     <= MODE_FIB;
      busy       <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
      ovf        <= 1'b0;
      term_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            n_q     <= count;
            mode_q  <= mode;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          a_q        <= WIDTH'(seed_t0(mode_q));
          b_q        <= WIDTH'(seed_t1(mode_q));
          a_c_q      <= 1'b0;
          b_c_q      <= 1'b0;
          idx_q      <= '0;
          term_valid <= 1'b1;
          state_q    <= StStream;
        end
        StStream: begin
          if (handshake) begin
            ovf <= ovf | a_c_q;
            // Compare before increment so the largest index never wraps idx_q.
            if (idx_q == n_q) begin
              data       <= a_q;
              busy       <= 1'b0;
              done       <= 1'b1;
              term_valid <= 1'b0;
              state_q    <= StFinish;
            end else begin
              a_q   <= b_q;
              a_c_q <= b_c_q;
              b_q   <= sum;
              b_c_q <= carry_out | a_c_q | b_c_q;
              idx_q <= idx_q + CNT_W'(1);
            end
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Scoreboard bench for fibo_seq_engine: a reference model queues expected terms and results,
// and a monitor compares them against every handshake and done pulse.
module tb_fibo_seq_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    int           lat;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] count = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  data;
  logic          ovf;
  logic          term_valid;
  logic [W-1:0]  term_data;
  logic          term_ready = 1'b0;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            policy = 0;
  int            hs_count = 0;
  int            stall_left = 0;
  logic [W-1:0]  exp_terms[$];
  res_t          exp_res[$];
  logic          holding = 1'b0;
  logic [W-1:0]  held = '0;

  fibo_seq_engine #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .data      (data),
    .ovf       (ovf),
    .term_valid(term_valid),
    .term_data (term_data),
    .term_ready(term_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: exact sequence values in wide integers, reduced modulo 2^W when emitted;
  // a run overflows iff any emitted exact term does not fit in W bits.
  task automatic push_model(input bit m, input int n, input bit chk_lat);
    longint t[$];
    longint lim;
    bit     ov;
    res_t   r;
    lim = longint'(1) << W;
    ov  = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i == 0) t.push_back(m ? 2 : 0);
      else if (i == 1) t.push_back(1);
      else t.push_back(t[i-1] + t[i-2]);
      exp_terms.push_back(W'(t[i] % lim));
      if (t[i] >= lim) ov = 1'b1;
    end
    r.data = W'(t[n] % lim);
    r.ovf  = ov;
    r.lat  = chk_lat ? n + 3 : -1;
    exp_res.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    case (policy)
      0: term_ready = 1'b1;
      1: term_ready = 1'($urandom_range(0, 1));
      default: begin
        if (hs_count == 2 && stall_left > 0) begin
          term_ready = 1'b0;
          stall_left--;
        end else begin
          term_ready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_valid", 64'(term_valid), 64'd1);
        check("hold_data", 64'(term_data), 64'(held));
      end
      holding = term_valid && !term_ready;
      held    = term_data;
      if (term_valid && !term_ready && policy == 2) check("bp_data", 64'(term_data), 64'd1);
      if (term_valid && term_ready) begin
        hs_count++;
        if (exp_terms.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_term actual=%0d required=none", term_data);
        end else begin
          check("term", 64'(term_data), 64'(exp_terms.pop_front()));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("data", 64'(data), 64'(r.data));
          check("ovf", 64'(ovf), 64'(r.ovf));
          check("stream_len_left", 64'(exp_terms.size()), 64'd0);
          check("busy_finish", 64'(busy), 64'd0);
          check("valid_finish", 64'(term_valid), 64'd0);
          if (r.lat >= 0) check("latency", 64'(cyc - start_cyc), 64'(r.lat));
        end
      end
    end
  end

  task automatic run(input bit m, input int n, input int pol, input bit poke);
    bit got;
    @(posedge clk);
    #1;
    policy   = pol;
    hs_count = 0;
    push_model(m, n, pol == 0);
    start_cyc = cyc;
    start = 1'b1;
    mode  = m;
    count = CW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 1'($urandom);
    count = CW'($urandom);
    check("busy_load", 64'(busy), 64'd1);
    check("valid_load", 64'(term_valid), 64'd0);
    check("ovf_clear", 64'(ovf), 64'd0);
    @(posedge clk);
    #1;
    check("first_valid", 64'(term_valid), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      if (poke && i == 6) begin
        start = 1'b1;
        mode  = 1'b1;
        count = CW'(9);
      end
      if (poke && i == 7) start = 1'b0;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
    if (poke) begin
      // Still in FINISH here; a start presented now must not launch a run.
      start = 1'b1;
      count = CW'(7);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("finish_start_ignored", 64'(busy), 64'd0);
      @(negedge clk);
      check("finish_start_ignored2", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_valid", 64'(term_valid), 64'd0);
    check("rst_tdata", 64'(term_data), 64'd0);
    rst_n = 1'b1;

    run(1'b0, 13, 0, 1'b0);
    run(1'b0, 14, 0, 1'b0);
    run(1'b1, 5, 0, 1'b0);
    run(1'b0, 0, 0, 1'b0);
    stall_left = 3;
    run(1'b0, 4, 2, 1'b1);
    run(1'b1, 15, 0, 1'b0);
    run(1'b0, 15, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run(1'($urandom), int'($urandom_range(0, (1 << CW) - 1)), int'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of a stream, after a run leaving data/ovf nonzero.
    run(1'b0, 14, 0, 1'b0);
    @(posedge clk);
    #1;
    policy = 0;
    push_model(1'b0, 10, 1'b0);
    start = 1'b1;
    mode  = 1'b0;
    count = CW'(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_data", 64'(data), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_valid", 64'(term_valid), 64'd0);
    check("mid_rst_tdata", 64'(term_data), 64'd0);
    exp_terms.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(1'b0, 3, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("no_pending_results", 64'(exp_res.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
